mem_access_ctrl: RTL and testbench

- Sequences data-memory accesses for the MEM stage, driven by the EX/MEM register outputs.
- Runs a req/ack handshake with a variable-latency data memory.
- Holds the pipeline through a global stall while an access is outstanding.
- Aborts hung accesses with a timeout and reports them as bus errors.

---
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access sequencer.
// Issues one registered req/ack transaction per load/store presented by the
// EX/MEM register. It holds the pipeline with a global stall while the access
// is outstanding. An access with no ack within TIMEOUT WAIT cycles is aborted
// and reported as a bus error.
// Optional build macro: MEM_ACCESS_PERF_EN adds the stall_cycles and err_count
// performance counters.

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        pc_rst,
  input  logic        m_mem_rd,
  input  logic        m_mem_wr,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        bus_err
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last WAIT count before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_r,   state_nxt_s;
  logic [7:0]  cnt_r,     cnt_nxt_s;
  logic        req_nxt_s, we_nxt_s, rd_valid_nxt_s, bus_err_nxt_s;
  logic [31:0] addr_nxt_s, wdata_nxt_s, rd_data_nxt_s;
  logic        access_s, stall_s;

  assign access_s = m_mem_rd | m_mem_wr;

  // Stall is combinational so the pipeline freezes in the cycle the access
  // is first seen; it is forced low while reset is asserted.
  assign stall = pc_rst & stall_s;

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    req_nxt_s      = mem_req;
    we_nxt_s       = mem_we;
    addr_nxt_s     = mem_addr;
    wdata_nxt_s    = mem_wdata;
    rd_data_nxt_s  = rd_data;
    rd_valid_nxt_s = 1'b0;
    bus_err_nxt_s  = 1'b0;
    stall_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s = access_s;
        if (access_s) begin
          // A simultaneous read and write issues as a write.
          addr_nxt_s  = m_addr;
          wdata_nxt_s = m_wdata;
          we_nxt_s    = m_mem_wr;
          req_nxt_s   = 1'b1;
          cnt_nxt_s   = 8'd0;
          state_nxt_s = ST_WAIT;
        end else begin
          req_nxt_s   = 1'b0;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          // Ack has priority over a timeout landing in the same cycle.
          req_nxt_s   = 1'b0;
          state_nxt_s = ST_DONE;
          if (!mem_we) begin
            rd_data_nxt_s  = mem_rdata;
            rd_valid_nxt_s = 1'b1;
          end else begin
            rd_valid_nxt_s = 1'b0;
          end
        end else if (cnt_r == CNT_LAST) begin
          req_nxt_s     = 1'b0;
          bus_err_nxt_s = 1'b1;
          state_nxt_s   = ST_DONE;
          if (!mem_we) begin
            rd_data_nxt_s  = ERR_RDATA;
            rd_valid_nxt_s = 1'b1;
          end else begin
            rd_valid_nxt_s = 1'b0;
          end
        end else if (cnt_r != 8'hFF) begin
          cnt_nxt_s = cnt_r + 8'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DONE: begin
        // Pipeline advances on this edge; never re-issue the same instruction.
        state_nxt_s = ST_IDLE;
      end
      default: begin
        req_nxt_s   = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered memory-interface outputs.
  always_ff @(posedge clk or negedge pc_rst) begin
    if (!pc_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rd_data   <= 32'd0;
      rd_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mem_req   <= req_nxt_s;
      mem_we    <= we_nxt_s;
      mem_addr  <= addr_nxt_s;
      mem_wdata <= wdata_nxt_s;
      rd_data   <= rd_data_nxt_s;
      rd_valid  <= rd_valid_nxt_s;
      bus_err   <= bus_err_nxt_s;
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  // Performance counters: wrapping stall-cycle count, saturating error count.
  always_ff @(posedge clk or negedge pc_rst) begin
    if (!pc_rst) begin
      stall_cycles <= 32'd0;
      err_count    <= 8'd0;
    end else begin
      if (stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (bus_err_nxt_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end else begin
        err_count <= err_count;
      end
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (default TIMEOUT=16).
module tb_mem_access_ctrl;

  logic        clk, pc_rst;
  logic        m_mem_rd, m_mem_wr;
  logic [31:0] m_addr, m_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, rd_valid, bus_err;
  logic [31:0] rd_data;

  int checks_r = 0;
  int errors_r = 0;

  mem_access_ctrl dut (
    .clk(clk), .pc_rst(pc_rst),
    .m_mem_rd(m_mem_rd), .m_mem_wr(m_mem_wr),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .rd_data(rd_data),
    .rd_valid(rd_valid), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access; ack_at = WAIT cycle (1-based) carrying mem_ack, 0 = never.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata,
                           input int exp_stall, input int exp_req, input logic exp_we,
                           input logic exp_rv, input logic [31:0] exp_rdata,
                           input logic exp_err);
    int st = 0;
    int rq = 0;
    bit done = 1'b0;
    logic [31:0] got_addr = 32'd0;
    logic [31:0] got_wdata = 32'd0;
    logic got_we = 1'b0;
    m_mem_rd = rd; m_mem_wr = wr; m_addr = addr; m_wdata = wdata;
    #1;
    for (int c = 0; c < 300 && !done; c++) begin
      if (stall) st++;
      if (mem_req) begin
        rq++;
        if (rq == 1) begin
          got_addr = mem_addr; got_wdata = mem_wdata; got_we = mem_we;
        end
        mem_ack   = (rq == ack_at);
        mem_rdata = (rq == ack_at) ? rdata : 32'hDEAD_BEEF;
      end else begin
        mem_ack = 1'b0;
      end
      if (!stall) done = 1'b1;
      else next_cycle();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stall_cyc"}, st, exp_stall);
    check({tag, "_req_cyc"}, rq, exp_req);
    if (exp_req > 0) begin
      check({tag, "_addr"}, got_addr, addr);
      check({tag, "_we"}, {31'd0, got_we}, {31'd0, exp_we});
      if (exp_we) check({tag, "_wdata"}, got_wdata, wdata);
    end
    check({tag, "_rv"}, {31'd0, rd_valid}, {31'd0, exp_rv});
    check({tag, "_berr"}, {31'd0, bus_err}, {31'd0, exp_err});
    check({tag, "_rdata"}, rd_data, exp_rdata);
    mem_ack = 1'b0;
    m_mem_rd = 1'b0; m_mem_wr = 1'b0;
    next_cycle();
    check({tag, "_post_rv"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_post_berr"}, {31'd0, bus_err}, 32'd0);
    check({tag, "_post_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_post_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_post_rdata"}, rd_data, exp_rdata);
  endtask

  logic [5:0] req_tr, stall_tr, rv_tr;

  initial begin
    pc_rst = 1'b0; m_mem_rd = 1'b0; m_mem_wr = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #12;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rv", {31'd0, rd_valid}, 32'd0);
    check("rst_rdata", rd_data, 32'd0);
    next_cycle();
    pc_rst = 1'b1;
    next_cycle();

    // Load, ack on first WAIT cycle.
    do_access("ld1", 1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hCAFE_F00D,
              2, 1, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    // Store, ack on third WAIT cycle; rd_data holds.
    do_access("st1", 1'b0, 1'b1, 32'h204, 32'h1234_5678, 3, 32'h0,
              4, 3, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
    // Load, never acked: timeout.
    do_access("to", 1'b1, 1'b0, 32'h080, 32'h0, 0, 32'h0,
              17, 16, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
    // Ack on the last timeout cycle wins.
    do_access("tolast", 1'b1, 1'b0, 32'h084, 32'h0, 16, 32'hA5A5_5A5A,
              17, 16, 1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0);
    // Read and write together: write issued.
    do_access("rdwr", 1'b1, 1'b1, 32'h300, 32'h0BAD_F00D, 2, 32'h7777_7777,
              3, 2, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0);

    // Non-memory instructions: zero stall.
    m_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nomem_stall", {31'd0, stall}, 32'd0);
      check("nomem_req", {31'd0, mem_req}, 32'd0);
      next_cycle();
    end

    // Back-to-back loads to 0x10 then 0x14, always acked; rdata = addr+0x1000.
    m_mem_rd = 1'b1; m_addr = 32'h10;
    #1;
    for (int c = 0; c < 6; c++) begin
      req_tr[c] = mem_req; stall_tr[c] = stall; rv_tr[c] = rd_valid;
      if (c == 2) begin
        check("b2b_rdata0", rd_data, 32'h0000_1010);
        m_addr = 32'h14;
      end
      if (c == 4) check("b2b_addr1", mem_addr, 32'h14);
      if (c == 5) begin
        check("b2b_rdata1", rd_data, 32'h0000_1014);
        m_mem_rd = 1'b0;
      end
      mem_ack = mem_req;
      mem_rdata = mem_addr + 32'h1000;
      next_cycle();
    end
    mem_ack = 1'b0;
    check("b2b_req_tr", {26'd0, req_tr}, {26'd0, 6'b010010});
    check("b2b_stall_tr", {26'd0, stall_tr}, {26'd0, 6'b011011});
    check("b2b_rv_tr", {26'd0, rv_tr}, {26'd0, 6'b100100});

    // Reset in the middle of WAIT.
    m_mem_rd = 1'b1; m_addr = 32'h500;
    next_cycle(); next_cycle(); next_cycle();
    check("midrst_pre_req", {31'd0, mem_req}, 32'd1);
    #2;
    pc_rst = 1'b0;
    #1;
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_rv", {31'd0, rd_valid}, 32'd0);
    check("midrst_berr", {31'd0, bus_err}, 32'd0);
    m_mem_rd = 1'b0;
    next_cycle();
    pc_rst = 1'b1;
    next_cycle();
    check("postrst_req", {31'd0, mem_req}, 32'd0);
    check("postrst_stall", {31'd0, stall}, 32'd0);
    // Controller back in IDLE: a fresh load behaves normally.
    do_access("ld2", 1'b1, 1'b0, 32'h600, 32'h0, 1, 32'h1357_9BDF,
              2, 1, 1'b0, 1'b1, 32'h1357_9BDF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
